// File: rtl/sccb_target.sv
// SCCB camera-side target: decodes 3-phase/2-phase writes and 2-phase reads onto a byte register port.
// sioc/siod are double-synchronised plus one history flop; siod_oe follows a pin edge by 3 PCLK, reg_we by 4.
`timescale 1ns/1ps
module sccb_target #(
    parameter logic [7:0] DEV_ID = 8'h42,
    parameter bit         ACK_EN = 1'b1
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       sioc,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
        S_WDAT, S_WDAT_ACK, S_RDAT, S_RD_NA, S_WAIT_STOP
    } state_t;

    state_t     state_q, state_d;
    logic       scl_m_q, scl_s_q, scl_h_q;
    logic       sda_m_q, sda_s_q, sda_h_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       we_pend_q, we_pend_d;
    logic       reg_we_q, reg_we_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_rise  = scl_s_q & ~scl_h_q;
    assign scl_fall  = ~scl_s_q & scl_h_q;
    assign start_det = scl_s_q & scl_h_q & ~sda_s_q & sda_h_q;
    assign stop_det  = scl_s_q & scl_h_q & sda_s_q & ~sda_h_q;
    assign byte_in   = {shift_q[6:0], sda_s_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        oe_d        = oe_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        we_pend_d   = 1'b0;
        reg_we_d    = we_pend_q;
        busy_d      = busy_q;
        // Bus conditions take priority over any sioc edge seen in the same cycle.
        if (start_det) begin
            state_d = S_ID;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ID, S_SUB, S_WDAT: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            case (state_q)
                                S_ID: begin
                                    if (byte_in[7:1] == DEV_ID[7:1]) begin
                                        rw_d    = byte_in[0];
                                        state_d = S_ID_ACK;
                                    end else begin
                                        state_d = S_WAIT_STOP;
                                    end
                                end
                                S_SUB: begin
                                    reg_addr_d = byte_in;
                                    state_d    = S_SUB_ACK;
                                end
                                default: begin
                                    reg_wdata_d = byte_in;
                                    we_pend_d   = 1'b1;
                                    state_d     = S_WDAT_ACK;
                                end
                            endcase
                        end
                    end
                end
                // cnt_q == 8 marks the fall opening the 9th bit; the ACK-bit rise clears it.
                S_ID_ACK, S_SUB_ACK, S_WDAT_ACK: begin
                    if (scl_rise) begin
                        cnt_d = 4'd0;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d = ACK_EN && !(state_q == S_ID_ACK && rw_q);
                        end else begin
                            oe_d  = 1'b0;
                            cnt_d = 4'd0;
                            case (state_q)
                                S_ID_ACK: begin
                                    if (rw_q) begin
                                        state_d = S_RDAT;
                                        shift_d = reg_rdata;
                                        oe_d    = ~reg_rdata[7];
                                    end else begin
                                        state_d = S_SUB;
                                    end
                                end
                                S_SUB_ACK: state_d = S_WDAT;
                                default:   state_d = S_WAIT_STOP;
                            endcase
                        end
                    end
                end
                S_RDAT: begin
                    if (scl_rise) begin
                        if (cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_RD_NA;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                S_RD_NA: begin
                    if (scl_rise) state_d = S_WAIT_STOP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            scl_m_q     <= 1'b1;
            scl_s_q     <= 1'b1;
            scl_h_q     <= 1'b1;
            sda_m_q     <= 1'b1;
            sda_s_q     <= 1'b1;
            sda_h_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'd0;
            rw_q        <= 1'b0;
            oe_q        <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            we_pend_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            scl_m_q     <= sioc;
            scl_s_q     <= scl_m_q;
            scl_h_q     <= scl_s_q;
            sda_m_q     <= siod_i;
            sda_s_q     <= sda_m_q;
            sda_h_q     <= sda_s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            oe_q        <= oe_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            we_pend_q   <= we_pend_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
        end
    end

    assign siod_oe   = oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-level SCCB master on an open-drain line plus a register array behind the port.
`timescale 1ns/1ps
module tb_sccb_target;
    logic       PCLK   = 1'b0;
    logic       PRESET = 1'b1;
    logic       sioc   = 1'b1;
    logic       sda_m  = 1'b1;
    logic       siod_i, siod_oe, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic [7:0] mem [256];

    int checks = 0, failures = 0;
    int H = 4;
    int cyc = 0, rise_cyc = 0, last8_cyc = 0;
    logic [7:0] model_addr = 8'h00;

    int we_cnt = 0, we_cyc = 0, we_long = 0, oe_hi_cnt = 0, busy_fall = 0;
    logic we_prev = 1'b0, busy_prev = 1'b0;
    logic [7:0] last_we_addr = 8'h00, last_we_data = 8'h00;

    assign siod_i    = sda_m & ~siod_oe;
    assign reg_rdata = mem[reg_addr];

    sccb_target #(.DEV_ID(8'h42), .ACK_EN(1'b1)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .sioc(sioc), .siod_i(siod_i), .siod_oe(siod_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        we_prev   <= reg_we;
        busy_prev <= busy;
        if (reg_we) begin
            we_cnt       <= we_cnt + 1;
            we_cyc       <= cyc;
            last_we_addr <= reg_addr;
            last_we_data <= reg_wdata;
            if (we_prev) we_long <= we_long + 1;
        end
        if (siod_oe) oe_hi_cnt <= oe_hi_cnt + 1;
        if (busy_prev && !busy) busy_fall <= busy_fall + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic m_start();
        if (!sioc) begin
            sda_m = 1'b1;
            wait_cyc(H - 1);
            sioc = 1'b1;
        end else begin
            sda_m = 1'b1;
        end
        wait_cyc(H);
        sda_m = 1'b0;
        wait_cyc(H);
        sioc = 1'b0;
        wait_cyc(1);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        wait_cyc(H - 1);
        sioc = 1'b1;
        wait_cyc(H);
        sda_m = 1'b1;
        wait_cyc(H);
    endtask

    // Data changes one PCLK after the sioc fall; the line is observed as sioc rises.
    task automatic m_bit(input logic b, output logic seen);
        sda_m = b;
        wait_cyc(H - 1);
        sioc     = 1'b1;
        seen     = siod_i;
        rise_cyc = cyc;
        wait_cyc(H);
        sioc = 1'b0;
        wait_cyc(1);
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        last8_cyc = rise_cyc;
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic m_rbyte(output logic [7:0] d, output logic na_line);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, s);
            d[i] = s;
        end
        m_bit(1'b1, na_line);
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        wait_cyc(4);
        checks++; if (siod_oe !== 1'b0)    begin failures++; $display("FAIL reset_oe got=%b exp=0", siod_oe); end
        checks++; if (reg_we !== 1'b0)     begin failures++; $display("FAIL reset_we got=%b exp=0", reg_we); end
        checks++; if (reg_addr !== 8'h00)  begin failures++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", reg_wdata); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        PRESET = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_three_phase_write();
        logic a1, a2, a3;
        int we0;
        we0 = we_cnt;
        H = 6;
        m_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL w3_busy_start got=%b exp=1", busy); end
        m_wbyte(8'h42, a1);
        m_wbyte(8'h12, a2);
        m_wbyte(8'h80, a3);
        m_stop();
        model_addr = 8'h12;
        mem[8'h12] = 8'h80;
        checks++; if ({a1, a2, a3} !== 3'b111) begin failures++; $display("FAIL w3_acks got=%b exp=111", {a1, a2, a3}); end
        checks++; if (we_cnt - we0 !== 1) begin failures++; $display("FAIL w3_we_count got=%0d exp=1", we_cnt - we0); end
        checks++; if (last_we_addr !== 8'h12) begin failures++; $display("FAIL w3_addr got=%h exp=12", last_we_addr); end
        checks++; if (last_we_data !== 8'h80) begin failures++; $display("FAIL w3_data got=%h exp=80", last_we_data); end
        checks++; if (we_cyc - last8_cyc !== 4) begin failures++; $display("FAIL w3_we_latency got=%0d exp=4", we_cyc - last8_cyc); end
        checks++; if (we_long !== 0) begin failures++; $display("FAIL w3_we_width got=%0d exp=0", we_long); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL w3_busy_stop got=%b exp=0", busy); end
    endtask

    task automatic test_write_then_read();
        logic a1, a2, a3, na;
        logic [7:0] d;
        int we0;
        we0 = we_cnt;
        H = 5;
        m_start(); m_wbyte(8'h42, a1); m_wbyte(8'h0A, a2); m_stop();
        model_addr = 8'h0A;
        mem[8'h0A] = 8'h76;
        m_start(); m_wbyte(8'h43, a3); m_rbyte(d, na); m_stop();
        checks++; if ({a1, a2} !== 2'b11) begin failures++; $display("FAIL wr_write_acks got=%b exp=11", {a1, a2}); end
        checks++; if (a3 !== 1'b0) begin failures++; $display("FAIL wr_read_id_bit9 got=%b exp=0", a3); end
        checks++; if (d !== 8'h76) begin failures++; $display("FAIL wr_rdata got=%h exp=76", d); end
        checks++; if (na !== 1'b1) begin failures++; $display("FAIL wr_na_released got=%b exp=1", na); end
        checks++; if (we_cnt !== we0) begin failures++; $display("FAIL wr_no_we got=%0d exp=%0d", we_cnt, we0); end
        checks++; if (reg_addr !== model_addr) begin failures++; $display("FAIL wr_addr_kept got=%h exp=%h", reg_addr, model_addr); end
    endtask

    task automatic test_id_mismatch();
        logic a1, a2, a3;
        int we0, oe0;
        we0 = we_cnt;
        oe0 = oe_hi_cnt;
        H = 4;
        m_start(); m_wbyte(8'h60, a1); m_wbyte(8'h33, a2); m_wbyte(8'h55, a3); m_stop();
        checks++; if ({a1, a2, a3} !== 3'b000) begin failures++; $display("FAIL mm_acks got=%b exp=000", {a1, a2, a3}); end
        checks++; if (oe_hi_cnt !== oe0) begin failures++; $display("FAIL mm_oe_cycles got=%0d exp=%0d", oe_hi_cnt, oe0); end
        checks++; if (we_cnt !== we0) begin failures++; $display("FAIL mm_no_we got=%0d exp=%0d", we_cnt, we0); end
        checks++; if (reg_addr !== model_addr) begin failures++; $display("FAIL mm_addr got=%h exp=%h", reg_addr, model_addr); end
    endtask

    task automatic test_repeated_start();
        logic a1, a2, a3, na;
        logic [7:0] d;
        int bf0;
        bf0 = busy_fall;
        H = 4;
        mem[8'h5C] = 8'($urandom);
        m_start(); m_wbyte(8'h42, a1); m_wbyte(8'h5C, a2);
        model_addr = 8'h5C;
        m_start(); m_wbyte(8'h43, a3); m_rbyte(d, na);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rs_busy got=%b exp=1", busy); end
        checks++; if (busy_fall !== bf0) begin failures++; $display("FAIL rs_busy_drop got=%0d exp=%0d", busy_fall, bf0); end
        m_stop();
        checks++; if ({a1, a2, a3} !== 3'b110) begin failures++; $display("FAIL rs_acks got=%b exp=110", {a1, a2, a3}); end
        checks++; if (d !== mem[8'h5C]) begin failures++; $display("FAIL rs_rdata got=%h exp=%h", d, mem[8'h5C]); end
        checks++; if (na !== 1'b1) begin failures++; $display("FAIL rs_na got=%b exp=1", na); end
    endtask

    task automatic test_abort_stop();
        logic a1, a2, s;
        int we0;
        we0 = we_cnt;
        H = 5;
        m_start(); m_wbyte(8'h42, a1); m_wbyte(8'h21, a2);
        model_addr = 8'h21;
        for (int i = 0; i < 4; i++) m_bit(1'($urandom), s);
        m_stop();
        wait_cyc(4);
        checks++; if (we_cnt !== we0) begin failures++; $display("FAIL ab_stop_no_we got=%0d exp=%0d", we_cnt, we0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ab_stop_busy got=%b exp=0", busy); end
        checks++; if (siod_oe !== 1'b0) begin failures++; $display("FAIL ab_stop_oe got=%b exp=0", siod_oe); end
        checks++; if (reg_addr !== model_addr) begin failures++; $display("FAIL ab_stop_addr got=%h exp=%h", reg_addr, model_addr); end
    endtask

    task automatic test_abort_reset();
        logic a1;
        int n, we0;
        we0 = we_cnt;
        H = 5;
        mem[model_addr] = 8'h00;
        m_start(); m_wbyte(8'h43, a1);
        n = 0;
        while (siod_oe !== 1'b1 && n < 20) begin
            wait_cyc(1);
            n++;
        end
        checks++; if (siod_oe !== 1'b1) begin failures++; $display("FAIL ar_read_drive got=%b exp=1", siod_oe); end
        PRESET = 1'b1;
        wait_cyc(1);
        checks++; if (siod_oe !== 1'b0) begin failures++; $display("FAIL ar_oe_release got=%b exp=0", siod_oe); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
        checks++; if (reg_addr !== 8'h00) begin failures++; $display("FAIL ar_addr got=%h exp=00", reg_addr); end
        PRESET = 1'b0;
        model_addr = 8'h00;
        sioc = 1'b1;
        sda_m = 1'b1;
        wait_cyc(2 * H);
        checks++; if (we_cnt !== we0) begin failures++; $display("FAIL ar_no_we got=%0d exp=%0d", we_cnt, we0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_glitch();
        logic a1, a2, a3;
        logic [7:0] ad, dd;
        int bf0, we0;
        bf0 = busy_fall;
        we0 = we_cnt;
        H = 4;
        ad = 8'hFF;
        dd = 8'h01;
        m_start(); m_wbyte(8'h42, a1); m_wbyte(ad, a2); m_wbyte(dd, a3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gl_busy got=%b exp=1", busy); end
        m_stop();
        mem[ad] = dd;
        model_addr = ad;
        checks++; if (busy_fall - bf0 !== 1) begin failures++; $display("FAIL gl_busy_drops got=%0d exp=1", busy_fall - bf0); end
        checks++; if (we_cnt - we0 !== 1) begin failures++; $display("FAIL gl_we_count got=%0d exp=1", we_cnt - we0); end
        checks++; if ({last_we_addr, last_we_data} !== {ad, dd}) begin failures++; $display("FAIL gl_write got=%h exp=%h", {last_we_addr, last_we_data}, {ad, dd}); end
        checks++; if ({a1, a2, a3} !== 3'b111) begin failures++; $display("FAIL gl_acks got=%b exp=111", {a1, a2, a3}); end
    endtask

    task automatic test_random();
        logic a1, a2, a3, na;
        logic [7:0] ad, dd, d, id;
        int kind, we0, oe0;
        for (int it = 0; it < 24; it++) begin
            H    = $urandom_range(4, 7);
            kind = $urandom_range(0, 3);
            ad   = 8'($urandom);
            dd   = 8'($urandom);
            we0  = we_cnt;
            oe0  = oe_hi_cnt;
            if (kind == 0) begin
                m_start(); m_wbyte(8'h42, a1); m_wbyte(ad, a2); m_wbyte(dd, a3); m_stop();
                mem[ad] = dd;
                model_addr = ad;
                checks++; if ({a1, a2, a3, 8'(we_cnt - we0)} !== {3'b111, 8'd1}) begin failures++; $display("FAIL rnd_w3_status it=%0d got=%b/%0d exp=111/1", it, {a1, a2, a3}, we_cnt - we0); end
                checks++; if ({last_we_addr, last_we_data} !== {ad, dd}) begin failures++; $display("FAIL rnd_w3_write it=%0d got=%h exp=%h", it, {last_we_addr, last_we_data}, {ad, dd}); end
            end else if (kind == 1 || kind == 2) begin
                if (kind == 1) begin
                    m_start(); m_wbyte(8'h42, a1); m_wbyte(ad, a2); m_stop();
                    model_addr = ad;
                end else begin
                    a1 = 1'b1;
                    a2 = 1'b1;
                end
                m_start(); m_wbyte(8'h43, a3); m_rbyte(d, na); m_stop();
                checks++; if ({a1, a2, a3, na} !== 4'b1101) begin failures++; $display("FAIL rnd_rd_status it=%0d got=%b exp=1101", it, {a1, a2, a3, na}); end
                checks++; if (d !== mem[model_addr]) begin failures++; $display("FAIL rnd_rd_data it=%0d got=%h exp=%h", it, d, mem[model_addr]); end
                checks++; if (we_cnt !== we0) begin failures++; $display("FAIL rnd_rd_no_we it=%0d got=%0d exp=%0d", it, we_cnt, we0); end
            end else begin
                id = 8'($urandom);
                while (id[7:1] == 7'h21) id = 8'($urandom);
                m_start(); m_wbyte(id, a1); m_wbyte(ad, a2); m_wbyte(dd, a3); m_stop();
                checks++; if ({oe_hi_cnt - oe0, we_cnt - we0} !== {32'd0, 32'd0}) begin failures++; $display("FAIL rnd_mm it=%0d id=%h got_oe=%0d got_we=%0d exp=0/0", it, id, oe_hi_cnt - oe0, we_cnt - we0); end
            end
            checks++; if (reg_addr !== model_addr) begin failures++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, reg_addr, model_addr); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_three_phase_write();
        test_write_then_read();
        test_id_mismatch();
        test_repeated_start();
        test_abort_stop();
        test_abort_reset();
        test_glitch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB target (camera-side responder) that decodes 3-phase write, 2-phase write and 2-phase read transactions arriving on `sioc`/`siod` and maps them onto a byte-wide register port. Serves as the camera model in loopback and bench setups for the SCCB APB master, and as a register back-end for an emulated sensor in the fabric. Everything runs on one fabric clock; `sioc`/`siod` are oversampled, never used as clocks.

## Interface
- `DEV_ID`, 8'h42: write ID. The read ID is `DEV_ID | 1`. Only bits [7:1] are compared.
- `ACK_EN`, 1: 1 = pull `siod` low during the 9th bit of matched write phases. 0 = never drive the 9th bit.
- `PCLK`  in  1  fabric clock; must be ≥ 8× the `sioc` frequency.
- `PRESET`  in  1  synchronous, active-high reset.
- `sioc`  in  1  SCCB clock from the master (asynchronous).
- `siod_i`  in  1  SCCB data, pad input (asynchronous).
- `siod_oe`  out  1  1 = pad pulls `siod` low (open drain). The pad never drives high.
- `reg_addr`  out  8  sub-address pointer.
- `reg_wdata`  out  8  write data; valid while `reg_we` = 1.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_rdata`  in  8  read data for `reg_addr`; sampled once per read phase.
- `busy`  out  1  1 from START to STOP.

## Operation
- **Synchronisation.** `sioc` and `siod_i` each pass through 2 flops, then 1 history flop. All edge detection uses the synchronised values.
  - START: `siod` falls while `sioc` = 1.
  - STOP: `siod` rises while `sioc` = 1.
  - Rise/fall: edges of `sioc`.
- **Bit transfer.**
  - Sample on `sioc` rise; bytes are MSB first.
  - Change `siod_oe` only in the cycle a `sioc` fall is detected.
  - The bit counter runs 0..8; index 8 is the don't-care/ACK bit.
- **States:** IDLE, ID, ID_ACK, SUB, SUB_ACK, WDAT, WDAT_ACK, RDAT, RD_NA, WAIT_STOP.
  - IDLE: on START, go to ID. Other line activity is ignored.
  - ID: after 8 bits, compare [7:1] with `DEV_ID[7:1]`.
    - Mismatch: go to WAIT_STOP with `siod_oe` = 0.
    - Match: go to ID_ACK and latch bit 0 as R/W.
  - ID_ACK:
    - On the `sioc` fall that starts bit 8: `siod_oe` = `ACK_EN` for a write, 0 for a read.
    - On the fall that ends bit 8: release, then go to SUB for a write or RDAT for a read.
  - SUB: the received byte loads `reg_addr`. SUB_ACK acknowledges as ID_ACK does, then go to WDAT.
  - WDAT: the received byte goes to `reg_wdata`.
    - `reg_we` pulses for 1 cycle, 1 cycle after the 8th rising sample.
    - WDAT_ACK acknowledges, then go to WAIT_STOP. Additional bytes are ignored; there is no auto-increment.
  - RDAT:
    - In the ID_ACK-ending fall cycle, load the shift register from `reg_rdata` and set `siod_oe` = ~bit7.
    - Each later fall shifts; `siod_oe` = ~current bit.
    - The fall after bit 0 releases the line, then go to RD_NA.
  - RD_NA: sample the master's NA bit (ignored), then go to WAIT_STOP.
- **Override events.**
  - START in any state → ID (repeated start).
  - STOP in any state → IDLE, with `siod_oe` = 0 in the same cycle.
- **Sub-address retention.** `reg_addr` persists across transactions, so a 2-phase write followed by a 2-phase read returns the addressed register.

## Timing
- **Reset values:** `siod_oe` = 0, `reg_we` = 0, `reg_addr` = 0, `reg_wdata` = 0, `busy` = 0, state IDLE, bit counter 0.
- **Pin-to-detect latency:** 3 `PCLK` cycles.
  - `siod_oe` changes 3 cycles after the `sioc` fall at the pin.
  - The master's data-valid window must therefore exceed 4 `PCLK`.
- **Write strobe:** `reg_we` asserts 4 cycles after the 8th data `sioc` rise at the pin, and lasts 1 cycle.
- **Read data:** `reg_rdata` must be valid in the ID_ACK-ending fall cycle; it is sampled exactly once.
- **Simultaneous events:** if START/STOP and an `sioc` edge are detected in the same cycle, START/STOP wins.
- **Mid-transfer reset:** `PRESET` asserted mid-transfer releases `siod` the next cycle.

## Test plan
- **3-phase write.** 3-phase write 0x42/0x12/0x80 with `ACK_EN` = 1 → `siod_oe` = 1 during all three 9th bits; one `reg_we` pulse with `reg_addr` = 0x12, `reg_wdata` = 0x80; `busy` = 0 after STOP.
- **Write-then-read.** 2-phase write 0x42/0x0A, STOP, then 2-phase read 0x43 with `reg_rdata` = 0x76 → master samples 0x76 MSB first; `siod_oe` = 0 during the NA bit; no `reg_we` pulse.
- **ID mismatch.** ID 0x60 → `siod_oe` stays 0 for the whole transaction; no `reg_we`; `reg_addr` unchanged.
- **Repeated start.** Repeated START after the sub-address phase, followed by read ID 0x43 → read of the just-loaded `reg_addr`; `busy` stays 1 throughout.
- **Abort.** STOP after 4 bits of WDAT, and separately `PRESET` during RDAT while `siod_oe` = 1 → `siod_oe` = 0 next cycle, state IDLE, no `reg_we`.
- **Glitch robustness.** `sioc` at `PCLK`/8 with `siod` transitions 1 cycle after `sioc` falls → no false START/STOP detected; all data bits correct.
